// File: rtl/xadc_channel_averager_if.sv
// Sample-stream / average-result bundle between the XADC reader side and the
// channel averager. Min/max tracking signals exist only when
// XADC_AVG_MINMAX_EN is defined.
interface xadc_channel_averager_if;
  logic [15:0] temp_data;
  logic        temp_ready;
  logic [15:0] voltage_data;
  logic        voltage_ready;
  logic        clear;
  logic [11:0] temp_avg;
  logic        temp_avg_valid;
  logic [11:0] volt_avg;
  logic        volt_avg_valid;
  logic        over_temp;
`ifdef XADC_AVG_MINMAX_EN
  logic [11:0] temp_min;
  logic [11:0] temp_max;
  logic [11:0] volt_min;
  logic [11:0] volt_max;

  modport master (
    output temp_data, temp_ready, voltage_data, voltage_ready, clear,
    input  temp_avg, temp_avg_valid, volt_avg, volt_avg_valid, over_temp,
    input  temp_min, temp_max, volt_min, volt_max
  );

  modport slave (
    input  temp_data, temp_ready, voltage_data, voltage_ready, clear,
    output temp_avg, temp_avg_valid, volt_avg, volt_avg_valid, over_temp,
    output temp_min, temp_max, volt_min, volt_max
  );
`else
  modport master (
    output temp_data, temp_ready, voltage_data, voltage_ready, clear,
    input  temp_avg, temp_avg_valid, volt_avg, volt_avg_valid, over_temp
  );

  modport slave (
    input  temp_data, temp_ready, voltage_data, voltage_ready, clear,
    output temp_avg, temp_avg_valid, volt_avg, volt_avg_valid, over_temp
  );
`endif
endinterface

// File: rtl/xadc_channel_averager.sv
// Block averager for the XADC temperature and VAUX15 sample streams.
// Each channel sums 2^AVG_LOG2 12-bit codes and publishes the floor mean with
// a one-cycle valid; the temperature mean also drives a hysteretic
// over-temperature flag. Optional min/max tracking of published averages is
// enabled by defining XADC_AVG_MINMAX_EN.
module xadc_channel_averager #(
  parameter int unsigned AVG_LOG2 = 4,
  parameter logic [11:0] OT_SET   = 12'hB5F,
  parameter logic [11:0] OT_CLR   = 12'hB0E
) (
  input logic                    clk,
  input logic                    reset,
  xadc_channel_averager_if.slave bus
);

  localparam int unsigned      ACC_W = 12 + AVG_LOG2;
  localparam int unsigned      CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic {ACCUM, PUBLISH} state_t;

  // Floor mean: a plain right shift truncates toward zero for unsigned sums.
  function automatic logic [11:0] block_mean(input logic [ACC_W-1:0] sum);
    block_mean = 12'(sum >> AVG_LOG2);
  endfunction

  // Channel 0 = temperature, channel 1 = voltage; the low nibble is not code.
  logic [11:0] code [2];
  logic        rdy  [2];
  logic        upd  [2];
  logic [11:0] nxt  [2];
  logic [11:0] avg  [2];
  logic        vld  [2];
  logic        unused_nibbles;

  assign code[0]        = bus.temp_data[15:4];
  assign code[1]        = bus.voltage_data[15:4];
  assign rdy[0]         = bus.temp_ready;
  assign rdy[1]         = bus.voltage_ready;
  assign unused_nibbles = ^{bus.temp_data[3:0], bus.voltage_data[3:0]};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t           state_p1, state_d;
    logic [ACC_W-1:0] acc_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic [11:0]      avg_p1;
    logic             last;
    logic [ACC_W-1:0] sum;

    assign last    = rdy[ch] && (cnt_p0 == LAST);
    assign sum     = acc_p0 + ACC_W'(code[ch]);
    assign upd[ch] = last && !bus.clear;
    assign nxt[ch] = block_mean(sum);
    assign avg[ch] = avg_p1;
    assign vld[ch] = (state_p1 == PUBLISH);

    // Next state: a completing sample publishes from either state, clear forces ACCUM.
    always_comb begin
      state_d = ACCUM;
      if (!bus.clear) begin
        case (state_p1)
          ACCUM:   if (last) state_d = PUBLISH;
          PUBLISH: if (last) state_d = PUBLISH;
          default: state_d = ACCUM;
        endcase
      end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) state_p1 <= ACCUM;
      else       state_p1 <= state_d;
    end

    // ---- stage p0: accumulate; stage p1: publish the block mean ----
    // Accumulator/counter; samples are taken in PUBLISH too so none are lost.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
        avg_p1 <= '0;
      end else if (bus.clear) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end else if (rdy[ch]) begin
        if (last) begin
          avg_p1 <= block_mean(sum);
          acc_p0 <= '0;
          cnt_p0 <= '0;
        end else begin
          acc_p0 <= sum;
          cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
      end
    end
  end : g_ch

  // Hysteretic over-temperature flag, evaluated only on a new temperature mean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.over_temp <= 1'b0;
    end else if (upd[0]) begin
      if (nxt[0] >= OT_SET)     bus.over_temp <= 1'b1;
      else if (nxt[0] < OT_CLR) bus.over_temp <= 1'b0;
    end
  end

  assign bus.temp_avg       = avg[0];
  assign bus.temp_avg_valid = vld[0];
  assign bus.volt_avg       = avg[1];
  assign bus.volt_avg_valid = vld[1];

`ifdef XADC_AVG_MINMAX_EN
  logic [11:0] mn [2];
  logic [11:0] mx [2];

  for (genvar ch = 0; ch < 2; ch++) begin : g_mm
    logic [11:0] min_p1, max_p1;

    assign mn[ch] = min_p1;
    assign mx[ch] = max_p1;

    // Track extremes of published means; the FFF/000 seeds make the first mean load both.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        min_p1 <= 12'hFFF;
        max_p1 <= 12'h000;
      end else if (bus.clear) begin
        min_p1 <= 12'hFFF;
        max_p1 <= 12'h000;
      end else if (upd[ch]) begin
        if (nxt[ch] < min_p1) min_p1 <= nxt[ch];
        if (nxt[ch] > max_p1) max_p1 <= nxt[ch];
      end
    end
  end : g_mm

  assign bus.temp_min = mn[0];
  assign bus.temp_max = mx[0];
  assign bus.volt_min = mn[1];
  assign bus.volt_max = mx[1];
`endif

endmodule

// File: tb/tb_xadc_channel_averager.sv
// Scoreboard bench for xadc_channel_averager with AVG_LOG2=2 (4 samples per
// average). Min/max checks are included when XADC_AVG_MINMAX_EN is defined.
module tb_xadc_channel_averager;

  typedef struct packed {
    logic [11:0] avg;
    logic        ot;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   tcyc   = -1;
  int   vcyc   = -2;
  exp_t        tq[$];
  logic [11:0] vq[$];

  xadc_channel_averager_if bus_if();

  xadc_channel_averager #(
    .AVG_LOG2(2),
    .OT_SET  (12'hB5F),
    .OT_CLR  (12'hB0E)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare whenever a valid is presented.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.temp_avg_valid) begin
        tcyc = cyc;
        if (tq.size() == 0) begin
          check("temp_unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = tq.pop_front();
          check("temp_avg", {20'd0, bus_if.temp_avg}, {20'd0, e.avg});
          check("over_temp", {31'd0, bus_if.over_temp}, {31'd0, e.ot});
        end
      end
      if (bus_if.volt_avg_valid) begin
        vcyc = cyc;
        if (vq.size() == 0) begin
          check("volt_unexpected_valid", 32'd1, 32'd0);
        end else begin
          logic [11:0] v;
          v = vq.pop_front();
          check("volt_avg", {20'd0, bus_if.volt_avg}, {20'd0, v});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic temp_sample(input logic [15:0] d);
    bus_if.temp_data  = d;
    bus_if.temp_ready = 1'b1;
    @(posedge clk);
    #1 bus_if.temp_ready = 1'b0;
  endtask

  task automatic temp_sample_clear(input logic [15:0] d);
    bus_if.temp_data  = d;
    bus_if.temp_ready = 1'b1;
    bus_if.clear      = 1'b1;
    @(posedge clk);
    #1;
    bus_if.temp_ready = 1'b0;
    bus_if.clear      = 1'b0;
  endtask

  task automatic both_sample(input logic [15:0] t, input logic [15:0] v);
    bus_if.temp_data     = t;
    bus_if.voltage_data  = v;
    bus_if.temp_ready    = 1'b1;
    bus_if.voltage_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.temp_ready    = 1'b0;
    bus_if.voltage_ready = 1'b0;
  endtask

  task automatic do_clear();
    bus_if.clear = 1'b1;
    @(posedge clk);
    #1 bus_if.clear = 1'b0;
  endtask

  // Four identical samples -> average equal to the code.
  task automatic temp_block(input logic [11:0] c, input logic ot);
    tq.push_back('{avg: c, ot: ot});
    for (int i = 0; i < 4; i++) temp_sample({c, 4'h0});
    idle(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                = 1'b1;
    bus_if.temp_data     = '0;
    bus_if.temp_ready    = 1'b0;
    bus_if.voltage_data  = '0;
    bus_if.voltage_ready = 1'b0;
    bus_if.clear         = 1'b0;
    idle(3);
    reset = 1'b0;

    // 1. Reset mid-block: two samples, then async reset.
    temp_sample(16'h1000);
    temp_sample(16'h2000);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    check("rst_temp_avg", {20'd0, bus_if.temp_avg}, 32'd0);
    check("rst_temp_valid", {31'd0, bus_if.temp_avg_valid}, 32'd0);
    check("rst_volt_avg", {20'd0, bus_if.volt_avg}, 32'd0);
    check("rst_volt_valid", {31'd0, bus_if.volt_avg_valid}, 32'd0);
    check("rst_over_temp", {31'd0, bus_if.over_temp}, 32'd0);
`ifdef XADC_AVG_MINMAX_EN
    check("rst_temp_min", {20'd0, bus_if.temp_min}, 32'hFFF);
    check("rst_temp_max", {20'd0, bus_if.temp_max}, 32'h000);
    check("rst_volt_min", {20'd0, bus_if.volt_min}, 32'hFFF);
    check("rst_volt_max", {20'd0, bus_if.volt_max}, 32'h000);
`endif

    // 2. (100+200+300+400)/4 = 280, valid the cycle after the 4th strobe.
    tq.push_back('{avg: 12'h280, ot: 1'b0});
    temp_sample(16'h1000);
    temp_sample(16'h2000);
    temp_sample(16'h3000);
    check("no_valid_before_4th", {31'd0, bus_if.temp_avg_valid}, 32'd0);
    temp_sample(16'h4000);
    check("valid_after_4th", {31'd0, bus_if.temp_avg_valid}, 32'd1);
    check("avg_after_4th", {20'd0, bus_if.temp_avg}, 32'h280);
    idle(1);
    check("valid_one_cycle", {31'd0, bus_if.temp_avg_valid}, 32'd0);
    idle(1);

    // 3. Hysteresis.
    temp_block(12'hB5F, 1'b1);
    temp_block(12'hB20, 1'b1);
    temp_block(12'hB0D, 1'b0);
    temp_block(12'hB0E, 1'b0);

    // 4. Simultaneous channels.
    tq.push_back('{avg: 12'h123, ot: 1'b0});
    vq.push_back(12'h0FF);
    for (int i = 0; i < 4; i++) both_sample(16'h1230, 16'h0FF0);
    idle(2);
    check("valids_same_cycle", tcyc, vcyc);

    // 5. clear with the 3rd strobe: sample dropped, averages/over_temp held.
    temp_block(12'hB5F, 1'b1);
    temp_sample(16'h1000);
    temp_sample(16'h2000);
    temp_sample_clear(16'h3000);
    check("clear_holds_avg", {20'd0, bus_if.temp_avg}, 32'hB5F);
    check("clear_holds_ot", {31'd0, bus_if.over_temp}, 32'd1);
    temp_sample(16'h4000);
    check("no_valid_after_clear", {31'd0, bus_if.temp_avg_valid}, 32'd0);
    tq.push_back('{avg: 12'h580, ot: 1'b0});
    temp_sample(16'h5000);
    temp_sample(16'h6000);
    temp_sample(16'h7000);
    idle(2);

    // 6. Min/max of published averages.
    do_clear();
    tq.push_back('{avg: 12'h280, ot: 1'b0});
    temp_sample(16'h1000);
    temp_sample(16'h2000);
    temp_sample(16'h3000);
    temp_sample(16'h4000);
    idle(2);
    temp_block(12'h100, 1'b0);
    temp_block(12'h300, 1'b0);
`ifdef XADC_AVG_MINMAX_EN
    check("temp_min", {20'd0, bus_if.temp_min}, 32'h100);
    check("temp_max", {20'd0, bus_if.temp_max}, 32'h300);
`endif
    do_clear();
`ifdef XADC_AVG_MINMAX_EN
    check("clr_volt_min", {20'd0, bus_if.volt_min}, 32'hFFF);
    check("clr_volt_max", {20'd0, bus_if.volt_max}, 32'h000);
`endif
    temp_block(12'h200, 1'b0);
`ifdef XADC_AVG_MINMAX_EN
    check("clr_temp_min", {20'd0, bus_if.temp_min}, 32'h200);
    check("clr_temp_max", {20'd0, bus_if.temp_max}, 32'h200);
`endif

    idle(3);
    check("temp_pending", tq.size(), 32'd0);
    check("volt_pending", vq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
